dmem_arbiter: RTL and testbench

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arbiter.sv | 151 +++++++++++++++
 tb/tb_dmem_arbiter.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one synchronous data memory among NUM_CORES cores.
// Combinational grant, registered memory request, two-stage read tag
// pipeline so read data returns to the granted core two cycles after grant.
// Build option: define DMEM_ARB_FIXED_PRIO_EN for fixed priority
// (lowest index wins); default build is round-robin.
`timescale 1ns/1ps

module dmem_arbiter #(
  parameter int unsigned NUM_CORES = 4,
  parameter int unsigned ADDR_W    = 16,
  parameter int unsigned DATA_W    = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_CORES-1:0]          core_req,
  input  logic [NUM_CORES-1:0]          core_wr,
  input  logic [NUM_CORES*ADDR_W-1:0]   core_addr,
  input  logic [NUM_CORES*DATA_W-1:0]   core_wdata,
  output logic [NUM_CORES-1:0]          core_gnt,
  output logic [NUM_CORES-1:0]          core_rvalid,
  output logic [DATA_W-1:0]             core_rdata,
  output logic [ADDR_W-1:0]             mem_addr,
  output logic                          mem_wr,
  output logic [DATA_W-1:0]             mem_wdata,
  input  logic [DATA_W-1:0]             mem_rdata
);

  localparam int unsigned IDX_W = $clog2(NUM_CORES);
  typedef logic [IDX_W-1:0] idx_t;

  logic                 w_found;
  idx_t                 w_win;
  logic                 w_grant;
  logic [NUM_CORES-1:0] w_cand;
  logic [NUM_CORES-1:0] w_gnt_oh;
  logic [ADDR_W-1:0]    w_sel_addr;
  logic [DATA_W-1:0]    w_sel_wdata;
  logic                 w_sel_wr;

  logic [ADDR_W-1:0]    r_mem_addr;
  logic [DATA_W-1:0]    r_mem_wdata;
  logic                 r_mem_wr;
  logic                 r_rd_v1;
  idx_t                 r_rd_idx1;
  logic                 r_rd_v2;
  idx_t                 r_rd_idx2;

`ifndef DMEM_ARB_FIXED_PRIO_EN
  idx_t                 r_ptr;
  idx_t                 w_ptr_nxt;
  logic [NUM_CORES-1:0] w_mask;
  logic [NUM_CORES-1:0] w_req_hi;

  // Round-robin: prefer requesters at or above the pointer, else wrap to the lowest
  always_comb begin
    w_mask = '0;
    for (int unsigned k = 0; k < NUM_CORES; k++) begin
      w_mask[k] = (idx_t'(k) >= r_ptr);
    end
    w_req_hi = core_req & w_mask;
    w_cand   = (|w_req_hi) ? w_req_hi : core_req;
  end
`else
  // Fixed priority: every requester is a candidate, lowest index wins below
  always_comb begin
    w_cand = core_req;
  end
`endif

  // Pick the lowest-index candidate as the winner
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    for (int unsigned k = 0; k < NUM_CORES; k++) begin
      if (!w_found && w_cand[k]) begin
        w_found = 1'b1;
        w_win   = idx_t'(k);
      end
    end
    w_grant = w_found & ~rst;
  end

  // Decode one-hot grant and mux the winner's request fields
  always_comb begin
    w_gnt_oh    = '0;
    w_sel_addr  = '0;
    w_sel_wdata = '0;
    w_sel_wr    = 1'b0;
    for (int unsigned k = 0; k < NUM_CORES; k++) begin
      if (w_grant && (w_win == idx_t'(k))) begin
        w_gnt_oh[k] = 1'b1;
        w_sel_addr  = core_addr[k*ADDR_W +: ADDR_W];
        w_sel_wdata = core_wdata[k*DATA_W +: DATA_W];
        w_sel_wr    = core_wr[k];
      end
    end
  end

`ifndef DMEM_ARB_FIXED_PRIO_EN
  assign w_ptr_nxt = (w_win == idx_t'(NUM_CORES - 1)) ? '0 : w_win + 1'b1;

  // Priority pointer moves just past the last granted core
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (w_grant) begin
      r_ptr <= w_ptr_nxt;
    end
  end
`endif

  // Register memory request and advance the read tag pipeline
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_wr    <= 1'b0;
      r_rd_v1     <= 1'b0;
      r_rd_idx1   <= '0;
      r_rd_v2     <= 1'b0;
      r_rd_idx2   <= '0;
    end else begin
      r_mem_wr <= w_grant & w_sel_wr;
      if (w_grant) begin
        r_mem_addr  <= w_sel_addr;
        r_mem_wdata <= w_sel_wdata;
      end
      r_rd_v1   <= w_grant & ~w_sel_wr;
      r_rd_idx1 <= w_win;
      r_rd_v2   <= r_rd_v1;
      r_rd_idx2 <= r_rd_idx1;
    end
  end

  // Return read strobe to the tagged core, suppressed while in reset
  always_comb begin
    core_rvalid = '0;
    for (int unsigned k = 0; k < NUM_CORES; k++) begin
      if (r_rd_v2 && !rst && (r_rd_idx2 == idx_t'(k))) begin
        core_rvalid[k] = 1'b1;
      end
    end
  end

  assign core_gnt   = w_gnt_oh;
  assign core_rdata = mem_rdata;
  assign mem_addr   = r_mem_addr;
  assign mem_wdata  = r_mem_wdata;
  assign mem_wr     = r_mem_wr;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed checks of grant order, memory request timing,
// read return latency, write behaviour and reset flushing.
`timescale 1ns/1ps

module tb_dmem_arbiter;

  localparam int N  = 4;
  localparam int AW = 16;
  localparam int DW = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    core_req;
  logic [N-1:0]    core_wr;
  logic [N*AW-1:0] core_addr;
  logic [N*DW-1:0] core_wdata;
  logic [N-1:0]    core_gnt;
  logic [N-1:0]    core_rvalid;
  logic [DW-1:0]   core_rdata;
  logic [AW-1:0]   mem_addr;
  logic            mem_wr;
  logic [DW-1:0]   mem_wdata;
  logic [DW-1:0]   mem_rdata;

  int n_checks = 0;
  int n_errors = 0;

  dmem_arbiter #(.NUM_CORES(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst),
    .core_req(core_req), .core_wr(core_wr),
    .core_addr(core_addr), .core_wdata(core_wdata),
    .core_gnt(core_gnt), .core_rvalid(core_rvalid), .core_rdata(core_rdata),
    .mem_addr(mem_addr), .mem_wr(mem_wr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Synchronous memory model: data for an address appears one cycle later
  always_ff @(posedge clk) mem_rdata <= mem_addr[7:0] ^ 8'hB5;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_core(input int k, input logic [15:0] a, input logic [7:0] d);
    core_addr[k*AW +: AW]  = a;
    core_wdata[k*DW +: DW] = d;
  endtask

  function automatic logic [3:0] oh(input int k);
    logic [3:0] v;
    v = '0;
    v[k] = 1'b1;
    return v;
  endfunction

  int g5[3];
  int eg;

  initial begin
    rst = 1'b1; core_req = '0; core_wr = '0; core_addr = '0; core_wdata = '0;
    #1;
    // Reset held with all cores requesting: no grant, no rvalid
    core_req = 4'b1111;
    @(negedge clk);
    check_eq("rst_gnt", core_gnt, 4'b0000);
    check_eq("rst_rvalid", core_rvalid, 4'b0000);
    next_cycle(); next_cycle();
    rst = 1'b0; core_req = '0;
    @(negedge clk);
    check_eq("post_rst_gnt", core_gnt, 4'b0000);
    check_eq("post_rst_rvalid", core_rvalid, 4'b0000);
    check_eq("post_rst_mem_wr", mem_wr, 1'b0);
    check_eq("post_rst_mem_addr", mem_addr, 16'h0000);
    check_eq("post_rst_mem_wdata", mem_wdata, 8'h00);
    next_cycle();

    // Single read from core 0 at 0x0010, memory returns 0xA5
    set_core(0, 16'h0010, 8'h00); core_req = 4'b0001; core_wr = 4'b0000;
    @(negedge clk);
    check_eq("rd0_gnt_T", core_gnt, 4'b0001);
    check_eq("rd0_rvalid_T", core_rvalid, 4'b0000);
    next_cycle(); core_req = '0;
    @(negedge clk);
    check_eq("rd0_mem_addr_T1", mem_addr, 16'h0010);
    check_eq("rd0_mem_wr_T1", mem_wr, 1'b0);
    check_eq("rd0_rvalid_T1", core_rvalid, 4'b0000);
    check_eq("rd0_gnt_T1", core_gnt, 4'b0000);
    next_cycle();
    @(negedge clk);
    check_eq("rd0_rvalid_T2", core_rvalid, 4'b0001);
    check_eq("rd0_rdata_T2", core_rdata, 8'hA5);
    next_cycle();
    @(negedge clk);
    check_eq("rd0_rvalid_T3", core_rvalid, 4'b0000);
    next_cycle();

    // Reset so the pointer is at 0, then all four cores read continuously
    rst = 1'b1; core_req = '0;
    next_cycle(); next_cycle();
    rst = 1'b0;
    for (int k = 0; k < N; k++) set_core(k, 16'h0020 + 16'(k), 8'h00);
    for (int i = 0; i < 10; i++) begin
      core_req = (i < 8) ? 4'b1111 : 4'b0000;
      @(negedge clk);
`ifdef DMEM_ARB_FIXED_PRIO_EN
      eg = 0;
`else
      eg = i % 4;
`endif
      check_eq($sformatf("rr_gnt_%0d", i), core_gnt, (i < 8) ? oh(eg) : 4'b0000);
      if (i >= 2) begin
`ifdef DMEM_ARB_FIXED_PRIO_EN
        eg = 0;
`else
        eg = (i - 2) % 4;
`endif
        check_eq($sformatf("rr_rvalid_%0d", i), core_rvalid, oh(eg));
        check_eq($sformatf("rr_rdata_%0d", i), core_rdata, (8'h20 + 8'(eg)) ^ 8'hB5);
      end else begin
        check_eq($sformatf("rr_rvalid_%0d", i), core_rvalid, 4'b0000);
      end
      next_cycle();
    end

    // Core 2 writes 0x3C to 0x0100: one write cycle, address held after, no rvalid
    set_core(2, 16'h0100, 8'h3C); core_req = 4'b0100; core_wr = 4'b0100;
    @(negedge clk);
    check_eq("wr2_gnt_T", core_gnt, 4'b0100);
    next_cycle(); core_req = '0; core_wr = '0;
    @(negedge clk);
    check_eq("wr2_mem_wr_T1", mem_wr, 1'b1);
    check_eq("wr2_mem_addr_T1", mem_addr, 16'h0100);
    check_eq("wr2_mem_wdata_T1", mem_wdata, 8'h3C);
    check_eq("wr2_rvalid_T1", core_rvalid, 4'b0000);
    next_cycle();
    @(negedge clk);
    check_eq("wr2_mem_wr_T2", mem_wr, 1'b0);
    check_eq("wr2_mem_addr_hold", mem_addr, 16'h0100);
    check_eq("wr2_mem_wdata_hold", mem_wdata, 8'h3C);
    check_eq("wr2_rvalid_T2", core_rvalid, 4'b0000);
    next_cycle();
    @(negedge clk);
    check_eq("wr2_rvalid_T3", core_rvalid, 4'b0000);
    next_cycle();

    // Pointer now at 3; cores 0 and 3 read: 3 then wrap to 0 then 3
`ifdef DMEM_ARB_FIXED_PRIO_EN
    g5 = '{0, 0, 0};
`else
    g5 = '{3, 0, 3};
`endif
    set_core(0, 16'h0030, 8'h00); set_core(3, 16'h0033, 8'h00);
    for (int i = 0; i < 5; i++) begin
      core_req = (i < 3) ? 4'b1001 : 4'b0000;
      @(negedge clk);
      check_eq($sformatf("wrap_gnt_%0d", i), core_gnt, (i < 3) ? oh(g5[i]) : 4'b0000);
      if (i >= 2) begin
        check_eq($sformatf("wrap_rvalid_%0d", i), core_rvalid, oh(g5[i-2]));
        check_eq($sformatf("wrap_rdata_%0d", i), core_rdata,
                 ((g5[i-2] == 3) ? 8'h33 : 8'h30) ^ 8'hB5);
      end
      next_cycle();
    end

    // Core 1 read granted, reset the next cycle: response must be dropped
    set_core(1, 16'h0041, 8'h00); core_req = 4'b0010;
    @(negedge clk);
    check_eq("flush_gnt_T", core_gnt, 4'b0010);
    next_cycle(); core_req = '0; rst = 1'b1;
    @(negedge clk);
    check_eq("flush_gnt_rst", core_gnt, 4'b0000);
    check_eq("flush_rvalid_rst", core_rvalid, 4'b0000);
    next_cycle(); rst = 1'b0;
    @(negedge clk);
    check_eq("flush_rvalid_T2", core_rvalid, 4'b0000);
    check_eq("flush_mem_addr", mem_addr, 16'h0000);
    check_eq("flush_mem_wr", mem_wr, 1'b0);
    next_cycle();
    @(negedge clk);
    check_eq("flush_rvalid_T3", core_rvalid, 4'b0000);
    next_cycle();
    // Pointer back at 0: with cores 1 and 2 requesting, core 1 wins
    core_req = 4'b0110;
    @(negedge clk);
    check_eq("ptr0_gnt", core_gnt, 4'b0010);
    next_cycle();
    // Lone requester is granted every cycle
    core_req = 4'b0100;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq($sformatf("solo_gnt_%0d", i), core_gnt, 4'b0100);
      next_cycle();
    end
    core_req = '0;
    next_cycle(); next_cycle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
